// File: rtl/alu_proto_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_proto_pkg
// Summary : Shared widths, initiator state encoding and command record for
//           the ALU handshake protocol.
// Revision: 1.0 - initial release
// ============================================================================
package alu_proto_pkg;

    localparam int c_DATA_W = 2;
    localparam int c_OP_W   = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        HS   = 3'd1,
        GAP  = 3'd2,
        CONF = 3'd3,
        EXEC = 3'd4,
        CAPT = 3'd5
    } init_state_t;

    typedef struct packed {
        logic [c_OP_W-1:0]   op;
        logic [c_DATA_W-1:0] a;
        logic [c_DATA_W-1:0] b;
    } cmd_t;

endpackage
`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
`default_nettype none
// ============================================================================
// Module  : alu_cmd_fifo
// Summary : Synchronous first-word-fall-through command queue.
// Revision: 1.0 - initial release
// ============================================================================
module alu_cmd_fifo
    import alu_proto_pkg::*;
#(
    parameter int WIDTH = $bits(cmd_t),
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;
    logic               w_push;
    logic               w_pop;

    assign o_full     = (r_count == (c_PTR_W+1)'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign o_pop_data = r_mem[r_rd_ptr];
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module  : alu_cmd_initiator
// Summary : Queues ALU commands, sequences the handshake/confirm exchange with
//           the responder and returns each captured result with a valid pulse.
// Revision: 1.0 - initial release
// ============================================================================
module alu_cmd_initiator
    import alu_proto_pkg::*;
#(
    parameter int DATA_W      = c_DATA_W,
    parameter int OP_W        = c_OP_W,
    parameter int FIFO_DEPTH  = 4,
    parameter int CONFIRM_DLY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    output logic              handshaking,
    output logic              confirm_op,
    output logic [OP_W-1:0]   switch_op,
    output logic [DATA_W-1:0] operand_a,
    output logic [DATA_W-1:0] operand_b,
    input  logic [DATA_W-1:0] alu_result,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              busy
);

    localparam int c_CMD_W = OP_W + 2*DATA_W;
    localparam int c_GAP_W = $clog2(CONFIRM_DLY + 1);
    localparam logic [c_GAP_W-1:0] c_GAP_LOAD =
        c_GAP_W'((CONFIRM_DLY >= 2) ? (CONFIRM_DLY - 2) : 0);

    init_state_t         r_state;
    init_state_t         w_next_state;
    logic [c_GAP_W-1:0]  r_gap_cnt;
    logic [OP_W-1:0]     r_switch_op;
    logic [DATA_W-1:0]   r_operand_a;
    logic [DATA_W-1:0]   r_operand_b;
    logic                r_result_valid;
    logic [DATA_W-1:0]   r_result_data;
    logic [c_CMD_W-1:0]  w_head;
    logic                w_full;
    logic                w_empty;
    logic                w_pop;

    assign w_pop = (r_state == IDLE) && !w_empty;

    alu_cmd_fifo #(
        .WIDTH (c_CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .i_push      (cmd_valid),
        .i_push_data ({cmd_op, cmd_a, cmd_b}),
        .i_pop       (w_pop),
        .o_pop_data  (w_head),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (!w_empty) w_next_state = HS;
            HS:      w_next_state = (CONFIRM_DLY == 1) ? CONF : GAP;
            GAP:     if (r_gap_cnt == '0) w_next_state = CONF;
            CONF:    w_next_state = EXEC;
            EXEC:    w_next_state = CAPT;
            CAPT:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= IDLE;
            r_gap_cnt      <= '0;
            r_switch_op    <= '0;
            r_operand_a    <= '0;
            r_operand_b    <= '0;
            r_result_valid <= 1'b0;
            r_result_data  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_pop) begin
                {r_switch_op, r_operand_a, r_operand_b} <= w_head;
            end
            // GAP lasts CONFIRM_DLY-1 cycles: load on HS, leave GAP at zero.
            if (r_state == HS) begin
                r_gap_cnt <= c_GAP_LOAD;
            end else if ((r_state == GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - 1'b1;
            end
            r_result_valid <= (r_state == CAPT);
            if (r_state == CAPT) begin
                r_result_data <= alu_result;
            end
        end
    end

    assign cmd_ready    = !w_full;
    assign handshaking  = (r_state == HS);
    assign confirm_op   = (r_state == CONF);
    assign busy         = (r_state != IDLE);
    assign switch_op    = r_switch_op;
    assign operand_a    = r_operand_a;
    assign operand_b    = r_operand_b;
    assign result_valid = r_result_valid;
    assign result_data  = r_result_data;

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_initiator.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_cmd_initiator
// Summary : Self-checking bench pairing two initiators (CONFIRM_DLY 1 and 3)
//           with cycle-accurate responder models.
// Revision: 1.0 - initial release
// ============================================================================
module tb_alu_cmd_initiator;

    localparam int DW = 2;
    localparam int OW = 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic          cmd_valid, cmd_ready, handshaking, confirm_op, result_valid, busy;
    logic [OW-1:0] cmd_op, switch_op;
    logic [DW-1:0] cmd_a, cmd_b, operand_a, operand_b, alu_result, result_data;

    logic          cmd_valid_3, cmd_ready_3, handshaking_3, confirm_op_3, result_valid_3, busy_3;
    logic [OW-1:0] cmd_op_3, switch_op_3;
    logic [DW-1:0] cmd_a_3, cmd_b_3, operand_a_3, operand_b_3, alu_result_3, result_data_3;

    alu_cmd_initiator #(.DATA_W(DW), .OP_W(OW), .FIFO_DEPTH(4), .CONFIRM_DLY(1)) u_dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .handshaking(handshaking),
        .confirm_op(confirm_op), .switch_op(switch_op), .operand_a(operand_a),
        .operand_b(operand_b), .alu_result(alu_result), .result_valid(result_valid),
        .result_data(result_data), .busy(busy)
    );

    alu_cmd_initiator #(.DATA_W(DW), .OP_W(OW), .FIFO_DEPTH(4), .CONFIRM_DLY(3)) u_dut3 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid_3), .cmd_ready(cmd_ready_3),
        .cmd_op(cmd_op_3), .cmd_a(cmd_a_3), .cmd_b(cmd_b_3), .handshaking(handshaking_3),
        .confirm_op(confirm_op_3), .switch_op(switch_op_3), .operand_a(operand_a_3),
        .operand_b(operand_b_3), .alu_result(alu_result_3), .result_valid(result_valid_3),
        .result_data(result_data_3), .busy(busy_3)
    );

    function automatic logic [DW-1:0] alu_f(input logic [OW-1:0] op,
                                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [DW-1:0] r;
        case (op)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a & b;
            default: r = a ^ b;
        endcase
        return r;
    endfunction

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_EXEC} rsp_t;
    rsp_t rs1, rs3;

    always @(posedge clk) begin
        if (reset) begin
            rs1 <= R_IDLE; alu_result <= '0;
        end else begin
            case (rs1)
                R_IDLE:  if (handshaking) rs1 <= R_WAIT;
                R_WAIT:  if (confirm_op) rs1 <= R_EXEC;
                default: begin alu_result <= alu_f(switch_op, operand_a, operand_b); rs1 <= R_IDLE; end
            endcase
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            rs3 <= R_IDLE; alu_result_3 <= '0;
        end else begin
            case (rs3)
                R_IDLE:  if (handshaking_3) rs3 <= R_WAIT;
                R_WAIT:  if (confirm_op_3) rs3 <= R_EXEC;
                default: begin alu_result_3 <= alu_f(switch_op_3, operand_a_3, operand_b_3); rs3 <= R_IDLE; end
            endcase
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push1(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b);
        cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [1:0] op, input logic [1:0] a,
                           input logic [1:0] b, input logic [1:0] exp);
        int lat;
        chk({name, " ready"}, cmd_ready, 1);
        push1(op, a, b);
        lat = 0;
        while (lat < 20) begin
            tick(); lat++;
            if (result_valid) break;
        end
        chk({name, " latency"}, lat, 5);
        chk({name, " data"}, result_data, exp);
    endtask

    typedef struct {
        logic [1:0] op;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs [8];
    logic [1:0] t2_cmd [5][3];
    logic [1:0] t2_exp [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, t, last;
        logic seen;

        vecs[0] = '{2'd0, 2'd1, 2'd2, 2'd3};
        vecs[1] = '{2'd0, 2'd3, 2'd3, 2'd2};
        vecs[2] = '{2'd1, 2'd0, 2'd1, 2'd3};
        vecs[3] = '{2'd1, 2'd3, 2'd1, 2'd2};
        vecs[4] = '{2'd2, 2'd3, 2'd2, 2'd2};
        vecs[5] = '{2'd2, 2'd1, 2'd2, 2'd0};
        vecs[6] = '{2'd3, 2'd1, 2'd3, 2'd2};
        vecs[7] = '{2'd3, 2'd2, 2'd2, 2'd0};
        t2_cmd[0] = '{2'd0, 2'd1, 2'd1}; t2_exp[0] = 2'd2;
        t2_cmd[1] = '{2'd1, 2'd2, 2'd3}; t2_exp[1] = 2'd3;
        t2_cmd[2] = '{2'd2, 2'd3, 2'd1}; t2_exp[2] = 2'd1;
        t2_cmd[3] = '{2'd3, 2'd2, 2'd1}; t2_exp[3] = 2'd3;
        t2_cmd[4] = '{2'd0, 2'd2, 2'd3}; t2_exp[4] = 2'd1;

        cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0;
        cmd_valid_3 = 0; cmd_op_3 = 0; cmd_a_3 = 0; cmd_b_3 = 0;
        reset = 1'b1;
        tick(); tick();
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst busy", busy, 0);
        chk("rst handshaking", handshaking, 0);
        chk("rst confirm_op", confirm_op, 0);
        chk("rst result_valid", result_valid, 0);
        chk("rst outputs", {switch_op, operand_a, operand_b, result_data}, 0);
        chk("rst dly3 ready", cmd_ready_3, 1);
        reset = 1'b0;
        tick();

        // Single command, cycle by cycle.
        push1(2'd1, 2'd2, 2'd1);
        tick();
        chk("t1 E1 handshaking", handshaking, 1);
        chk("t1 E1 confirm_op", confirm_op, 0);
        chk("t1 E1 busy", busy, 1);
        chk("t1 E1 hold", {switch_op, operand_a, operand_b}, {2'd1, 2'd2, 2'd1});
        tick();
        chk("t1 E2 confirm_op", confirm_op, 1);
        chk("t1 E2 handshaking", handshaking, 0);
        tick(); tick();
        chk("t1 E4 busy", busy, 1);
        chk("t1 E4 result_valid", result_valid, 0);
        tick();
        chk("t1 E5 result_valid", result_valid, 1);
        chk("t1 E5 result_data", result_data, 1);
        tick();
        chk("t1 E6 pulse width", result_valid, 0);

        for (int i = 0; i < 8; i++) begin
            run_one($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp);
        end
        tick();

        // Five consecutive pushes: queue fills while the first is in flight.
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t2 ready before push %0d", i), cmd_ready, 1);
            cmd_valid = 1'b1; cmd_op = t2_cmd[i][0]; cmd_a = t2_cmd[i][1]; cmd_b = t2_cmd[i][2];
            tick();
        end
        cmd_valid = 1'b0;
        chk("t2 queue full", cmd_ready, 0);
        k = 0; t = 0; last = 0;
        while (k < 5 && t < 60) begin
            tick(); t++;
            if (result_valid) begin
                chk($sformatf("t2 data %0d", k), result_data, t2_exp[k]);
                chk($sformatf("t2 timing %0d", k), t - last, (k == 0) ? 1 : 5);
                last = t; k++;
            end
        end
        chk("t2 result count", k, 5);
        tick();

        // Push coinciding with the IDLE pop at count 1.
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 2'd3; cmd_b = 2'd3;
        tick();
        cmd_op = 2'd3; cmd_a = 2'd1; cmd_b = 2'd0;
        tick();
        cmd_valid = 1'b0;
        chk("t5 E1 handshaking", handshaking, 1);
        chk("t5 E1 hold", {switch_op, operand_a, operand_b}, {2'd2, 2'd3, 2'd3});
        tick(); tick(); tick(); tick();
        chk("t5 E5 result_valid", result_valid, 1);
        chk("t5 E5 data", result_data, 3);
        tick();
        chk("t5 E6 handshaking", handshaking, 1);
        chk("t5 E6 hold", {switch_op, operand_a, operand_b}, {2'd3, 2'd1, 2'd0});
        tick(); tick(); tick(); tick();
        chk("t5 E10 result_valid", result_valid, 1);
        chk("t5 E10 data", result_data, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || result_valid) seen = 1'b1;
        end
        chk("t5 no extra command", seen, 0);

        // Input changes during a transaction must not disturb the hold registers.
        push1(2'd1, 2'd3, 2'd1);
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 2'd0; cmd_b = 2'd3;
            end else begin
                cmd_valid = 1'b0; cmd_op = 2'(i); cmd_a = 2'(i + 1); cmd_b = 2'(3 - i);
            end
            tick();
            chk($sformatf("t6 hold E%0d", i), {switch_op, operand_a, operand_b}, {2'd1, 2'd3, 2'd1});
        end
        cmd_valid = 1'b0;
        tick();
        chk("t6 E5 data", result_data, 2);
        tick();
        chk("t6 E6 hold reload", {switch_op, operand_a, operand_b}, {2'd0, 2'd0, 2'd3});
        t = 0;
        while (!result_valid && t < 20) begin tick(); t++; end
        chk("t6 second result seen", result_valid, 1);
        chk("t6 second data", result_data, 3);
        tick(); tick();

        // Reset during CONF abandons the transaction and flushes the queue.
        push1(2'd1, 2'd1, 2'd1);
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_a = 2'd3; cmd_b = 2'd3;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t4 in CONF", confirm_op, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t4 busy", busy, 0);
        chk("t4 strobes", {handshaking, confirm_op, result_valid}, 0);
        chk("t4 held outputs", {switch_op, operand_a, operand_b, result_data}, 0);
        chk("t4 cmd_ready", cmd_ready, 1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (busy || result_valid) seen = 1'b1;
        end
        chk("t4 queue flushed", seen, 0);
        run_one("t4 fresh", 2'd0, 2'd2, 2'd1, 2'd3);

        // CONFIRM_DLY = 3 instance.
        cmd_valid_3 = 1'b1; cmd_op_3 = 2'd3; cmd_a_3 = 2'd2; cmd_b_3 = 2'd3;
        tick();
        cmd_valid_3 = 1'b0;
        tick();
        chk("t3 E1 handshaking", handshaking_3, 1);
        chk("t3 E1 confirm_op", confirm_op_3, 0);
        for (int e = 2; e <= 3; e++) begin
            tick();
            chk($sformatf("t3 E%0d strobes", e), {handshaking_3, confirm_op_3}, 0);
            chk($sformatf("t3 E%0d responder wait", e), rs3, R_WAIT);
        end
        tick();
        chk("t3 E4 confirm_op", confirm_op_3, 1);
        chk("t3 E4 responder wait", rs3, R_WAIT);
        tick(); tick();
        chk("t3 E6 result_valid", result_valid_3, 0);
        tick();
        chk("t3 E7 result_valid", result_valid_3, 1);
        chk("t3 E7 data", result_data_3, 1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
